// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 width codes, FSM state encoding,
// word geometry and a helper that maps (we, funct3) to an access size.
// Unlisted funct3 codes (and load-only codes seen on a store) fall back to word size.
package lsu_pkg;

  localparam int BYTES_PER_WORD = 4;

  // RV32I width codes as they appear in funct3 of loads and stores
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // FSM encoding kept as plain constants so older tools see simple vectors
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_RESP = 2'd2;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unsigned variants only exist for loads; a store with 100/101 is a word store
  function automatic size_e access_size(input logic we, input logic [2:0] funct3);
    if (funct3 == F3_B || (!we && funct3 == F3_BU)) begin
      return SZ_B;
    end else if (funct3 == F3_H || (!we && funct3 == F3_HU)) begin
      return SZ_H;
    end
    return SZ_W;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic: store data replication / byte enables,
// the misalignment check, and load lane extraction with sign/zero extension.
// The store side and the load side take independent funct3/address inputs.
module lsu_align import lsu_pkg::*; (
  input  logic        st_we_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  size_e      st_size;
  size_e      ld_size;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic       ld_uns;

  // Store lane placement and alignment check for the incoming request
  always_comb begin
    st_size    = access_size(st_we_i, st_funct3_i);
    st_data_o  = st_data_i;
    st_be_o    = 4'b1111;
    misalign_o = 1'b0;
    case (st_size)
      SZ_B: begin
        st_data_o = {4{st_data_i[7:0]}};
        st_be_o   = 4'b0001 << st_addr_i;
      end
      SZ_H: begin
        st_data_o  = {2{st_data_i[15:0]}};
        st_be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = st_addr_i[0];
      end
      default: begin
        misalign_o = |st_addr_i;
      end
    endcase
  end

  // Load lane selection and extension for the held request
  always_comb begin
    ld_size = access_size(1'b0, ld_funct3_i);
    ld_uns  = ld_funct3_i[2];
    case (ld_addr_i)
      2'd0:    ld_byte = ld_raw_i[7:0];
      2'd1:    ld_byte = ld_raw_i[15:8];
      2'd2:    ld_byte = ld_raw_i[23:16];
      default: ld_byte = ld_raw_i[31:24];
    endcase
    ld_half = ld_addr_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    case (ld_size)
      SZ_B:    ld_data_o = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data_o = {{16{~ld_uns & ld_half[15]}}, ld_half};
      default: ld_data_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: accept -> mem access -> one-cycle response.
// Latency: accept N, mem_valid N+1, resp_valid N+2 (misaligned: resp_valid N+1); mem_ready stalls BUSY.
// Backpressure: req_ready only in IDLE. `define LSU_STATS_EN adds load/store/stall counters.
module load_store_unit import lsu_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_w_data,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_w_data,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  input  logic [DATA_WIDTH-1:0]   mem_r_data,
  input  logic                    mem_ready
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]             stat_loads,
  output logic [31:0]             stat_stores,
  output logic [31:0]             stat_stall_cycles
`endif
);

  state_t                  state_q, state_d;
  logic                    we_q;
  logic [2:0]              funct3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;

  logic                    accept;
  logic                    done;
  logic [DATA_WIDTH-1:0]   st_data;
  logic [DATA_WIDTH/8-1:0] st_be;
  logic                    misalign;
  logic [DATA_WIDTH-1:0]   ld_data;

  assign accept = req_valid && (state_q == S_IDLE);
  assign done   = (state_q == S_BUSY) && mem_ready;

  lsu_align u_align (
    .st_we_i     (req_we),
    .st_funct3_i (req_funct3),
    .st_addr_i   (req_addr[1:0]),
    .st_data_i   (req_w_data),
    .st_data_o   (st_data),
    .st_be_o     (st_be),
    .misalign_o  (misalign),
    .ld_funct3_i (funct3_q),
    .ld_addr_i   (addr_q[1:0]),
    .ld_raw_i    (mem_r_data),
    .ld_data_o   (ld_data)
  );

  // Next-state: misaligned requests skip the memory and respond directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = misalign ? S_RESP : S_BUSY;
      S_BUSY:  if (mem_ready) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request hold registers and captured load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q        <= req_we;
        funct3_q    <= req_funct3;
        addr_q      <= req_addr;
        wdata_q     <= req_we ? st_data : '0;
        be_q        <= req_we ? st_be : '1;
        err_q       <= misalign;
        resp_data_q <= '0;
      end else if (done) begin
        resp_data_q <= we_q ? '0 : ld_data;
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_err    = err_q && resp_valid;
  assign resp_data   = resp_data_q;
  assign mem_valid   = (state_q == S_BUSY);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_w_data  = wdata_q;
  assign mem_byte_en = be_q;

`ifdef LSU_STATS_EN
  logic [31:0] loads_q, stores_q, stalls_q;

  // Free-running wrap-around counters of completed accesses and stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      stalls_q <= '0;
    end else begin
      if (done && !we_q) loads_q  <= loads_q + 32'd1;
      if (done && we_q)  stores_q <= stores_q + 32'd1;
      if ((state_q == S_BUSY) && !mem_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_loads        = loads_q;
  assign stat_stores       = stores_q;
  assign stat_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset values, store lane placement,
// load extension, stalls, misalignment and reset during an access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_w_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_r_data;
  logic        mem_ready;
`ifdef LSU_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_stall_cycles;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_w_data  (req_w_data),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_w_data  (mem_w_data),
    .mem_byte_en (mem_byte_en),
    .mem_r_data  (mem_r_data),
    .mem_ready   (mem_ready)
`ifdef LSU_STATS_EN
    ,
    .stat_loads        (stat_loads),
    .stat_stores       (stat_stores),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one cycle; returns in cycle N+1
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_w_data = wd;
    step();
    req_valid  = 1'b0;
    req_w_data = 32'h0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_w_data = 32'h0; mem_r_data = 32'h0; mem_ready = 1'b1;
    step();
    step();
    chk("rst_req_ready",  32'(req_ready), 32'd1);
    chk("rst_mem_valid",  32'(mem_valid), 32'd0);
    chk("rst_mem_we",     32'(mem_we), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err",   32'(resp_err), 32'd0);
    chk("rst_resp_data",  resp_data, 32'h0);
    chk("rst_mem_addr",   mem_addr, 32'h0);
    chk("rst_mem_w_data", mem_w_data, 32'h0);
    chk("rst_byte_en",    32'(mem_byte_en), 32'h0);
    rst = 1'b0;
    step();

    // SW 0x100
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_mem_valid", 32'(mem_valid), 32'd1);
    chk("sw_mem_we",    32'(mem_we), 32'd1);
    chk("sw_req_ready", 32'(req_ready), 32'd0);
    chk("sw_addr",      mem_addr, 32'h100);
    chk("sw_be",        32'(mem_byte_en), 32'hF);
    chk("sw_wdata",     mem_w_data, 32'hDEADBEEF);
    chk("sw_resp_n1",   32'(resp_valid), 32'd0);
    step();
    chk("sw_resp_valid", 32'(resp_valid), 32'd1);
    chk("sw_resp_err",   32'(resp_err), 32'd0);
    chk("sw_resp_data",  resp_data, 32'h0);
    chk("sw_mem_valid_off", 32'(mem_valid), 32'd0);
    step();
    chk("sw_resp_pulse", 32'(resp_valid), 32'd0);
    chk("sw_idle_ready", 32'(req_ready), 32'd1);

    // SB 0x103
    issue(1'b1, 3'b000, 32'h103, 32'h000000A5);
    chk("sb_be",    32'(mem_byte_en), 32'h8);
    chk("sb_wdata", mem_w_data, 32'hA5A5A5A5);
    step();
    chk("sb_resp", 32'(resp_valid), 32'd1);
    step();

    // SH 0x102
    issue(1'b1, 3'b001, 32'h102, 32'hFFFF1234);
    chk("sh_be",    32'(mem_byte_en), 32'hC);
    chk("sh_wdata", mem_w_data, 32'h12341234);
    step();
    step();

    // LB / LBU at 0x102
    mem_r_data = 32'h0080FF00;
    issue(1'b0, 3'b000, 32'h102, 32'h0);
    chk("lb_mem_we", 32'(mem_we), 32'd0);
    chk("lb_be",     32'(mem_byte_en), 32'hF);
    step();
    chk("lb_resp_valid", 32'(resp_valid), 32'd1);
    chk("lb_data", resp_data, 32'hFFFFFF80);
    step();
    issue(1'b0, 3'b100, 32'h102, 32'h0);
    step();
    chk("lbu_data", resp_data, 32'h00000080);
    step();

    // LH / LHU
    mem_r_data = 32'h80011234;
    issue(1'b0, 3'b001, 32'h002, 32'h0);
    step();
    chk("lh_hi_data", resp_data, 32'hFFFF8001);
    step();
    issue(1'b0, 3'b101, 32'h000, 32'h0);
    step();
    chk("lhu_lo_data", resp_data, 32'h00001234);
    step();

    // LW 0x200 with four stall cycles
    mem_ready = 1'b0;
    mem_r_data = 32'hCAFEF00D;
    issue(1'b0, 3'b010, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lw_stall%0d_valid", i), 32'(mem_valid), 32'd1);
      chk($sformatf("lw_stall%0d_addr", i), mem_addr, 32'h200);
      chk($sformatf("lw_stall%0d_noresp", i), 32'(resp_valid), 32'd0);
      step();
    end
    mem_ready = 1'b1;
    chk("lw_last_valid", 32'(mem_valid), 32'd1);
    chk("lw_last_addr",  mem_addr, 32'h200);
    step();
    chk("lw_resp_valid", 32'(resp_valid), 32'd1);
    chk("lw_data", resp_data, 32'hCAFEF00D);
    step();
`ifdef LSU_STATS_EN
    chk("stat_stall", stat_stall_cycles, 32'd4);
    chk("stat_loads", stat_loads, 32'd5);
    chk("stat_stores", stat_stores, 32'd3);
`endif

    // LH 0x201 misaligned
    issue(1'b0, 3'b001, 32'h201, 32'h0);
    chk("mis_lh_mem_valid", 32'(mem_valid), 32'd0);
    chk("mis_lh_resp_valid", 32'(resp_valid), 32'd1);
    chk("mis_lh_err", 32'(resp_err), 32'd1);
    chk("mis_lh_data", resp_data, 32'h0);
    step();
    chk("mis_lh_pulse", 32'(resp_valid), 32'd0);

    // SW 0x102 misaligned
    issue(1'b1, 3'b010, 32'h102, 32'h11111111);
    chk("mis_sw_mem_valid", 32'(mem_valid), 32'd0);
    chk("mis_sw_err", 32'(resp_err), 32'd1);
    step();
`ifdef LSU_STATS_EN
    chk("stat_loads_mis", stat_loads, 32'd5);
`endif

    // Reset during the 2nd stall cycle
    mem_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    step();
    chk("rb_stall2_valid", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    chk("rb_mem_valid", 32'(mem_valid), 32'd0);
    chk("rb_req_ready", 32'(req_ready), 32'd1);
    chk("rb_resp_valid", 32'(resp_valid), 32'd0);
`ifdef LSU_STATS_EN
    chk("rb_stat_stall", stat_stall_cycles, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rb_no_resp%0d", i), 32'(resp_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width (only 32 supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  pipeline presents a load/store.
REQ-007 req_ready  out  1  unit can accept a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  RV32I width code: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
REQ-010 req_addr  in  ADDR_WIDTH  byte address.
REQ-011 req_w_data  in  DATA_WIDTH  store source, LSB-justified.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_data  out  DATA_WIDTH  aligned, extended load result; 0 for stores and errors.
REQ-014 resp_err  out  1  misaligned access, qualified by resp_valid.
REQ-015 mem_valid / mem_we  out  1 each  request strobe and write flag to the MMU.
REQ-016 mem_addr  out  ADDR_WIDTH  held request address, unmodified.
REQ-017 mem_w_data  out  DATA_WIDTH; mem_byte_en  out  DATA_WIDTH/8  lane-placed store data and enables.
REQ-018 mem_r_data  in  DATA_WIDTH  valid only in the completion cycle; mem_ready  in  1  completion/stall from the MMU.

Function
REQ-019 SHALL implement the states S_IDLE, S_BUSY, and S_RESP.
REQ-020 req_ready SHALL be 1 only in S_IDLE; a request is accepted on req_valid && req_ready.
REQ-021 On acceptance, the unit SHALL register we, funct3, and addr, and SHALL register lane-placed data and byte_en.
REQ-022 An aligned request SHALL go to S_BUSY; a misaligned request SHALL go to S_RESP with err=1 and SHALL NOT drive mem_valid.
REQ-023 Misaligned SHALL mean a halfword with addr[0]=1, or a word with addr[1:0]!=0; a byte access is never misaligned.
REQ-024 In S_BUSY, mem_valid SHALL be 1 and all mem_* outputs SHALL be held constant from the registers until mem_ready=1.
REQ-025 A transfer SHALL complete in the first S_BUSY cycle with mem_ready=1; the unit SHALL capture mem_r_data in that cycle and then go to S_RESP.
REQ-026 mem_ready low in any S_BUSY cycle, including the first (same-cycle miss), SHALL extend S_BUSY with no upper bound.
REQ-027 In S_RESP, resp_valid SHALL be 1 for exactly one cycle, then the unit SHALL return to S_IDLE.
REQ-028 Best-case latency: accept at N, mem_valid at N+1, resp_valid at N+2; a misaligned request gives resp_valid at N+1.
REQ-029 Store lanes SHALL be: SB replicates byte 4x with byte_en = 4'b0001 << addr[1:0]; SH replicates halfword 2x with byte_en = addr[1] ? 1100 : 0011; SW uses byte_en 1111.
REQ-030 Loads SHALL drive mem_we=0 and byte_en=1111, and SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-031 A funct3 outside the REQ-009 codes SHALL be treated as a word access.
REQ-032 mem_valid SHALL never be 1 outside S_BUSY; there SHALL be one outstanding access, with no pipelining.

Reset
REQ-033 On rst, the state SHALL go to S_IDLE and req_ready SHALL be 1 after reset.
REQ-034 On rst, mem_valid, mem_we, resp_valid, and resp_err SHALL be 0.
REQ-035 On rst, resp_data, mem_addr, mem_w_data, and mem_byte_en SHALL be 0.
REQ-036 rst during S_BUSY SHALL abandon the access: mem_valid is 0 from the next cycle and no resp_valid is produced.

Configuration
REQ-037 Macro LSU_STATS_EN SHALL control the performance counters.
REQ-038 With LSU_STATS_EN defined, the unit SHALL add the outputs stat_loads[31:0], stat_stores[31:0], and stat_stall_cycles[31:0].
REQ-039 stat_loads and stat_stores SHALL increment per completed aligned access; stat_stall_cycles SHALL increment per S_BUSY cycle with mem_ready=0; all SHALL wrap at 2^32 and clear on rst.
REQ-040 Without LSU_STATS_EN, these ports and counters SHALL be absent and function SHALL be identical.

Structure
REQ-041 Package lsu_pkg SHALL hold the funct3 width enum, state_t, and the BYTES_PER_WORD constant.
REQ-042 Combinational sub-module lsu_align SHALL hold store lane placement, load extraction/extension, and the misalign check.

Verification
REQ-043 SW at 0x100 with data 0xDEADBEEF and mem_ready=1 -> mem_byte_en=1111, mem_w_data=0xDEADBEEF, resp_valid at N+2, resp_err=0.
REQ-044 SB at 0x103 with data 0x000000A5 -> byte_en=1000, mem_w_data=0xA5A5A5A5.
REQ-045 LB at 0x102 with mem_r_data=0x0080FF00 -> resp_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-046 LW at 0x200 with mem_ready low for 4 cycles -> mem_addr/mem_valid stable for 5 cycles, resp_valid one cycle after ready, stall counter +4 (LSU_STATS_EN).
REQ-047 LH at 0x201 -> no mem_valid, resp_valid at N+1 with resp_err=1 and resp_data=0.
REQ-048 rst asserted in the 2nd stall cycle -> mem_valid=0 next cycle, no resp_valid, req_ready=1.
